// File: rtl/fp_unit_scheduler_pkg.sv
// Shared types for the FP unit scheduler.
// Holds the FP opcode enum, the canonical quiet NaN, the response flag
// struct, the scheduler FSM states and a small opcode helper.
package fp_unit_scheduler_pkg;

    typedef enum logic [1:0] {
        FP_OP_ADD  = 2'd0,
        FP_OP_SUB  = 2'd1,
        FP_OP_MUL  = 2'd2,
        FP_OP_RSVD = 2'd3
    } fp_op_e;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] bits;
    } fp_t;

    typedef struct packed {
        logic timeout;
        logic invalid_op;
    } fp_flags_t;

    localparam fp_flags_t FLAGS_NONE    = '{timeout: 1'b0, invalid_op: 1'b0};
    localparam fp_flags_t FLAGS_INVALID = '{timeout: 1'b0, invalid_op: 1'b1};
    localparam fp_flags_t FLAGS_TIMEOUT = '{timeout: 1'b1, invalid_op: 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

    // Reserved opcodes never reach the execution unit.
    function automatic logic op_is_rsvd(input fp_op_e op);
        return (op == FP_OP_RSVD);
    endfunction

endpackage

// File: rtl/fp_unit_scheduler_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - index of the highest-priority requester this cycle
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - binary index of the granted requester
module fp_rr_arbiter
    import fp_unit_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found_s;

    // Circular scan starting at ptr; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [IDX_W-1:0] cand_s;
            cand_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fp_unit_scheduler.sv
// Shares one multi-cycle FP execution unit between NUM_REQ requesters.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   req_valid/ready/op/a/b   - issue ports (ready is a one-hot grant, IDLE only)
//   rsp_valid/ready          - one-hot response handshake
//   rsp_result, rsp_flags    - shared response bus, flags = {timeout, invalid_op}
//   unit_start/op/a/b        - start pulse and captured operands to the FP unit
//   unit_done, unit_result   - completion pulse and result from the FP unit
//   unit_abort               - one-cycle pulse when the watchdog expires
module fp_unit_scheduler
    import fp_unit_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_result,
    output logic [1:0]              rsp_flags,
    output logic                    unit_start,
    output logic [1:0]              unit_op,
    output logic [31:0]             unit_a,
    output logic [31:0]             unit_b,
    input  logic                    unit_done,
    input  logic [31:0]             unit_result,
    output logic                    unit_abort
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    sched_state_e       state_r, state_s;
    logic [IDX_W-1:0]   ptr_r, idx_r, win_idx_s, ptr_next_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [TMR_W-1:0]   timer_r;
    fp_op_e             op_r, win_op_s;
    fp_t                a_r, b_r, result_r, win_a_s, win_b_s;
    fp_flags_t          flags_r;
    logic [1:0]         win_op_bits_s;
    logic               start_r, accept_s, expire_s;

    fp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (win_idx_s)
    );

    // Operand mux for the current winner (grant is one-hot, so OR-select).
    always_comb begin
        win_op_bits_s = 2'b00;
        win_a_s.bits  = 32'h0000_0000;
        win_b_s.bits  = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_op_bits_s = win_op_bits_s | ({2{grant_s[i]}} & req_op[2*i +: 2]);
            win_a_s.bits  = win_a_s.bits  | ({32{grant_s[i]}} & req_a[32*i +: 32]);
            win_b_s.bits  = win_b_s.bits  | ({32{grant_s[i]}} & req_b[32*i +: 32]);
        end
        win_op_s   = fp_op_e'(win_op_bits_s);
        ptr_next_s = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : (win_idx_s + IDX_W'(1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state, grant and abort strobes.
    always_comb begin
        state_s    = state_r;
        req_ready  = '0;
        accept_s   = 1'b0;
        expire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready = grant_s;
                    accept_s  = 1'b1;
                    state_s   = op_is_rsvd(win_op_s) ? ST_RESP : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle still wins.
                if (unit_done) begin
                    state_s = ST_RESP;
                end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                    expire_s = 1'b1;
                    state_s  = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready[idx_r]) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        unit_abort = expire_s;
    end

    // Capture registers, watchdog timer and response latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r    <= '0;
            idx_r    <= '0;
            op_r     <= FP_OP_ADD;
            a_r      <= '0;
            b_r      <= '0;
            start_r  <= 1'b0;
            timer_r  <= '0;
            result_r <= '0;
            flags_r  <= FLAGS_NONE;
        end else begin
            start_r <= accept_s && !op_is_rsvd(win_op_s);
            if (accept_s) begin
                ptr_r <= ptr_next_s;
                idx_r <= win_idx_s;
                if (op_is_rsvd(win_op_s)) begin
                    // Unit operands stay untouched for a rejected opcode.
                    result_r.bits <= FP_CANON_NAN;
                    flags_r       <= FLAGS_INVALID;
                end else begin
                    op_r <= win_op_s;
                    a_r  <= win_a_s;
                    b_r  <= win_b_s;
                end
            end
            if (state_r == ST_ISSUE) begin
                timer_r <= '0;
            end else if (state_r == ST_WAIT) begin
                timer_r <= timer_r + TMR_W'(1);
            end
            // Done outside WAIT (late or post-reset) is deliberately dropped.
            if (state_r == ST_WAIT && unit_done) begin
                result_r.bits <= unit_result;
                flags_r       <= FLAGS_NONE;
            end else if (expire_s) begin
                result_r.bits <= FP_CANON_NAN;
                flags_r       <= FLAGS_TIMEOUT;
            end
        end
    end

    // One-hot response valid decoded from the registered state and index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state_r == ST_RESP) && (idx_r == IDX_W'(i));
        end
    end

    assign unit_start = start_r;
    assign unit_op    = op_r;
    assign unit_a     = a_r.bits;
    assign unit_b     = b_r.bits;
    assign rsp_result = result_r.bits;
    assign rsp_flags  = flags_r;

endmodule

// File: tb/tb_fp_unit_scheduler.sv
// Self-checking bench for fp_unit_scheduler (NUM_REQ=4, TIMEOUT=64).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fp_unit_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = 4'b0000;
    logic [3:0]   req_ready;
    logic [7:0]   req_op = 8'h00;
    logic [127:0] req_a = 128'h0;
    logic [127:0] req_b = 128'h0;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready = 4'b0000;
    logic [31:0]  rsp_result;
    logic [1:0]   rsp_flags;
    logic         unit_start;
    logic [1:0]   unit_op;
    logic [31:0]  unit_a, unit_b;
    logic         unit_done = 1'b0;
    logic [31:0]  unit_result = 32'h0;
    logic         unit_abort;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] res;
        logic [1:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // FP unit stand-in: done pulse unit_delay cycles after start.
    int          unit_delay = 1;
    bit          upend = 1'b0;
    int          ucnt = 0;
    logic [1:0]  uop;
    logic [31:0] ua, ub;

    fp_unit_scheduler #(.NUM_REQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_result(unit_result), .unit_abort(unit_abort)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] unit_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        unit_done = 1'b0;
        if (upend) begin
            ucnt = ucnt - 1;
            if (ucnt <= 0) begin
                unit_done   = 1'b1;
                unit_result = unit_fn(uop, ua, ub);
                upend       = 1'b0;
            end
        end
        if (unit_start) begin
            upend = 1'b1;
            ucnt  = unit_delay;
            uop   = unit_op;
            ua    = unit_a;
            ub    = unit_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2]  = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, unit_start, unit_abort, unit_op} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy=%b v=%b st=%b ab=%b op=%b expected all 0",
                     req_ready, rsp_valid, unit_start, unit_abort, unit_op);
        end
        vectors++;
        if ({unit_a, unit_b, rsp_result, rsp_flags} !== 98'h0) begin
            miscompares++;
            $display("FAIL reset_data: got a=%h b=%h r=%h f=%b expected 0", unit_a, unit_b, rsp_result, rsp_flags);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        unit_delay = 1;
        set_req(0, 2'd0, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        sb.push_back('{idx: 2'd0, res: 32'h4040_0000, flg: 2'b00});
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        vectors++;
        if (unit_start !== 1'b1 || unit_op !== 2'd0 || unit_a !== 32'h3F80_0000 || unit_b !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL single_start: got st=%b op=%h a=%h b=%h expected 1 0 3f800000 40000000",
                     unit_start, unit_op, unit_a, unit_b);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0000 || unit_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_c2: got v=%b st=%b expected 0000 0", rsp_valid, unit_start);
        end
        tick();
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (rsp_valid !== (4'b0001 << e.idx) || rsp_result !== e.res || rsp_flags !== e.flg) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%b r=%h f=%b expected v=%b r=%h f=%b",
                     rsp_valid, rsp_result, rsp_flags, 4'b0001 << e.idx, e.res, e.flg);
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_release: got %b expected 0000", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int g = 0;
        int r = 0;
        int cyc = 0;
        logic [1:0]  ops[4];
        logic [31:0] as[4];
        logic [31:0] bs[4];
        do_reset();
        unit_delay = 1;
        ops = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 4; i++) begin
            as[i] = 32'h1000_0000 * (i + 1) + 32'h0000_0123;
            bs[i] = 32'h0000_1111 * (i + 3);
            set_req(i, ops[i], as[i], bs[i]);
        end
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        while (r < 5 && cyc < 200) begin
            @(negedge clk);
            if (|req_ready) begin
                vectors++;
                if (req_ready !== (4'b0001 << (g % 4))) begin
                    miscompares++;
                    $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, 4'b0001 << (g % 4));
                end
                sb.push_back('{idx: 2'(g % 4), res: unit_fn(ops[g % 4], as[g % 4], bs[g % 4]), flg: 2'b00});
                g++;
            end
            if (|rsp_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rr_rsp: got v=%b expected no response", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== (4'b0001 << e.idx) || rsp_result !== e.res || rsp_flags !== e.flg) begin
                        miscompares++;
                        $display("FAIL rr_rsp: got v=%b r=%h f=%b expected v=%b r=%h f=%b",
                                 rsp_valid, rsp_result, rsp_flags, 4'b0001 << e.idx, e.res, e.flg);
                    end
                end
                r++;
            end
            tick();
            cyc++;
        end
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        vectors++;
        if (r != 5) begin
            miscompares++;
            $display("FAIL rr_count: got %0d responses expected 5", r);
        end
    endtask

    task automatic test_rsvd();
        exp_t e;
        int starts = 0;
        do_reset();
        set_req(2, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        req_valid = 4'b0100;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL rsvd_grant: got %b expected 0100", req_ready);
        end
        sb.push_back('{idx: 2'd2, res: 32'h7FC0_0000, flg: 2'b01});
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        if (unit_start) starts++;
        e = sb.pop_front();
        vectors++;
        if (rsp_valid !== (4'b0001 << e.idx) || rsp_result !== e.res || rsp_flags !== e.flg) begin
            miscompares++;
            $display("FAIL rsvd_rsp: got v=%b r=%h f=%b expected v=%b r=%h f=%b",
                     rsp_valid, rsp_result, rsp_flags, 4'b0001 << e.idx, e.res, e.flg);
        end
        rsp_ready = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            rsp_ready = 4'b0000;
            @(negedge clk);
            if (unit_start) starts++;
        end
        vectors++;
        if (starts != 0 || unit_op !== 2'd0) begin
            miscompares++;
            $display("FAIL rsvd_unit: got %0d starts op=%h expected 0 starts op=0", starts, unit_op);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int n = 0;
        int bad = 0;
        do_reset();
        unit_delay = 100;
        set_req(1, 2'd2, 32'h4040_0000, 32'h4080_0000);
        req_valid = 4'b0010;
        @(negedge clk);
        sb.push_back('{idx: 2'd1, res: 32'h7FC0_0000, flg: 2'b10});
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        vectors++;
        if (unit_start !== 1'b1) begin
            miscompares++;
            $display("FAIL to_start: got %b expected 1", unit_start);
        end
        while (n < 200) begin
            tick();
            n++;
            @(negedge clk);
            if (unit_abort === 1'b1) break;
        end
        vectors++;
        if (n != 64) begin
            miscompares++;
            $display("FAIL to_abort_delay: got %0d cycles expected 64", n);
        end
        tick();
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (rsp_valid !== (4'b0001 << e.idx) || rsp_result !== e.res || rsp_flags !== e.flg || unit_abort !== 1'b0) begin
            miscompares++;
            $display("FAIL to_rsp: got v=%b r=%h f=%b ab=%b expected v=%b r=%h f=%b ab=0",
                     rsp_valid, rsp_result, rsp_flags, unit_abort, 4'b0001 << e.idx, e.res, e.flg);
        end
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = 4'b0000;
        // The unit's late done lands in this window and must be ignored.
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000 || unit_start !== 1'b0 || unit_abort !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL to_stray_done: got %0d disturbed cycles expected 0", bad);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int bad = 0;
        logic [31:0] r3;
        do_reset();
        unit_delay = 1;
        r3 = unit_fn(2'd1, 32'hC000_0000, 32'h3F00_0000);
        set_req(3, 2'd1, 32'hC000_0000, 32'h3F00_0000);
        set_req(0, 2'd2, 32'h4100_0000, 32'h4110_0000);
        req_valid = 4'b1000;
        @(negedge clk);
        sb.push_back('{idx: 2'd3, res: r3, flg: 2'b00});
        tick();
        req_valid = 4'b0001;
        tick();
        tick();
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 4'b1000 || rsp_result !== e.res || rsp_flags !== e.flg || req_ready !== 4'b0000) begin
                miscompares++;
                bad++;
                $display("FAIL bp_hold%0d: got v=%b r=%h f=%b rdy=%b expected v=1000 r=%h f=%b rdy=0000",
                         i, rsp_valid, rsp_result, rsp_flags, req_ready, e.res, e.flg);
            end
            if (i == 9) rsp_ready = 4'b1000;
            else rsp_ready = 4'b0001;
            tick();
        end
        rsp_ready = 4'b0000;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001 || rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_regrant: got rdy=%b v=%b expected 0001 0000", req_ready, rsp_valid);
        end
        sb.push_back('{idx: 2'd0, res: unit_fn(2'd2, 32'h4100_0000, 32'h4110_0000), flg: 2'b00});
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (rsp_valid !== (4'b0001 << e.idx) || rsp_result !== e.res || rsp_flags !== e.flg) begin
            miscompares++;
            $display("FAIL bp_rsp2: got v=%b r=%h f=%b expected v=%b r=%h f=%b",
                     rsp_valid, rsp_result, rsp_flags, 4'b0001 << e.idx, e.res, e.flg);
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        int bad = 0;
        int g = 0;
        int r = 0;
        int cyc = 0;
        logic [3:0] drop;
        do_reset();
        unit_delay = 5;
        set_req(0, 2'd0, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, unit_start, unit_abort, unit_op, unit_a, unit_b, rsp_result, rsp_flags} !== 110'h0) begin
            miscompares++;
            $display("FAIL rw_outputs: got v=%b st=%b op=%h a=%h b=%h r=%h f=%b expected all 0",
                     rsp_valid, unit_start, unit_op, unit_a, unit_b, rsp_result, rsp_flags);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            if (rsp_valid !== 4'b0000 || unit_start !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rw_pending_done: got %0d disturbed cycles expected 0", bad);
        end
        tick();
        unit_delay = 1;
        set_req(0, 2'd1, 32'h0000_0500, 32'h0000_0200);
        set_req(1, 2'd2, 32'hAAAA_0000, 32'h0000_5555);
        req_valid = 4'b0011;
        rsp_ready = 4'b0011;
        while (r < 2 && cyc < 100) begin
            @(negedge clk);
            drop = req_ready;
            if (|req_ready) begin
                vectors++;
                if (req_ready !== (4'b0001 << g)) begin
                    miscompares++;
                    $display("FAIL rw_grant%0d: got %b expected %b", g, req_ready, 4'b0001 << g);
                end
                if (g == 0) sb.push_back('{idx: 2'd0, res: 32'h0000_0300, flg: 2'b00});
                else sb.push_back('{idx: 2'd1, res: 32'hAAAA_5555, flg: 2'b00});
                g++;
            end
            if (|rsp_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rw_rsp: got v=%b expected no response", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== (4'b0001 << e.idx) || rsp_result !== e.res || rsp_flags !== e.flg) begin
                        miscompares++;
                        $display("FAIL rw_rsp: got v=%b r=%h f=%b expected v=%b r=%h f=%b",
                                 rsp_valid, rsp_result, rsp_flags, 4'b0001 << e.idx, e.res, e.flg);
                    end
                end
                r++;
            end
            tick();
            req_valid = req_valid & ~drop;
            cyc++;
        end
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        vectors++;
        if (r != 2) begin
            miscompares++;
            $display("FAIL rw_count: got %0d responses expected 2", r);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rsvd();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
